// File: rtl/fifo_burst_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader_if
// Bus bundle for fifo_burst_reader: the read port of a first-word-fall-through
// FIFO (i_rempty / i_rdata / o_rinc) plus the valid/ready output stream
// (o_data / o_valid / i_ready). Signal names keep the reader's point of view.
//   master : the burst reader (pops the FIFO, sources the stream)
//   slave  : the environment (FIFO read side and downstream sink)
// -----------------------------------------------------------------------------
interface fifo_burst_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_rempty;
    logic [DATA_WIDTH-1:0] i_rdata;
    logic                  o_rinc;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_valid;
    logic                  i_ready;

    modport master (
        input  i_rempty,
        input  i_rdata,
        input  i_ready,
        output o_rinc,
        output o_data,
        output o_valid
    );

    modport slave (
        output i_rempty,
        output i_rdata,
        output i_ready,
        input  o_rinc,
        input  o_data,
        input  o_valid
    );
endinterface

// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
// Pops exactly i_len words from a fall-through FIFO and forwards them on a
// valid/ready stream through a 2-entry output buffer, at one word per cycle
// when downstream is always ready.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_start, i_len    burst command and length (sampled only in IDLE)
//   i_abort           terminate the running burst
//   bus (master)      FIFO read port and output stream
//   o_busy            high while a burst is in READ or DRAIN
//   o_done/o_aborted  one-cycle completion / abort pulses
//   o_count           words handshaken downstream in the current/last burst
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [LEN_WIDTH-1:0] i_len,
    input  logic                 i_abort,
    fifo_burst_reader_if.master  bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_aborted,
    output logic [LEN_WIDTH-1:0] o_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  valid_q, busy_q, done_q, aborted_q;
    logic                  done_d, aborted_d;
    logic                  pop_s, hs_s;

    // Pop and handshake strobes; pop is suppressed by abort, a full buffer and reset.
    always_comb begin
        pop_s = (state_q == ST_READ) && (rem_q != LEN_ZERO) && !bus.i_rempty &&
                (occ_q != 2'd2) && !i_abort && !i_rst;
        hs_s  = valid_q && bus.i_ready;
    end

    // Next-state logic for the burst FSM, output buffer and counters.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        count_d   = count_q;
        occ_d     = occ_q;
        head_d    = head_q;
        tail_d    = tail_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        // Buffer: head is the word presented downstream, tail the second slot.
        // A pop that coincides with a handshake keeps occupancy constant.
        if (pop_s && hs_s) begin
            if (occ_q == 2'd1) begin
                head_d = bus.i_rdata;
            end else begin
                head_d = tail_q;
                tail_d = bus.i_rdata;
            end
        end else if (pop_s) begin
            if (occ_q == 2'd0) begin
                head_d = bus.i_rdata;
            end else begin
                tail_d = bus.i_rdata;
            end
            occ_d = occ_q + 2'd1;
        end else if (hs_s) begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
        end else begin
            occ_d = occ_q;
        end

        if (pop_s) begin
            rem_d = rem_q - LEN_ONE;
        end else begin
            rem_d = rem_q;
        end

        // A handshake in the abort cycle is still counted.
        if (hs_s) begin
            count_d = count_q + LEN_ONE;
        end else begin
            count_d = count_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    count_d = LEN_ZERO;
                    if (i_len != LEN_ZERO) begin
                        rem_d   = i_len;
                        state_d = ST_READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (i_abort) begin
                    state_d   = ST_IDLE;
                    rem_d     = LEN_ZERO;
                    occ_d     = 2'd0;
                    head_d    = DATA_ZERO;
                    aborted_d = 1'b1;
                end else if (pop_s && (rem_q == LEN_ONE)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_DRAIN: begin
                // Abort takes priority over a completing handshake.
                if (i_abort) begin
                    state_d   = ST_IDLE;
                    rem_d     = LEN_ZERO;
                    occ_d     = 2'd0;
                    head_d    = DATA_ZERO;
                    aborted_d = 1'b1;
                end else if (hs_s && (occ_q == 2'd1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                rem_d   = LEN_ZERO;
                occ_d   = 2'd0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            rem_q     <= LEN_ZERO;
            count_q   <= LEN_ZERO;
            occ_q     <= 2'd0;
            head_q    <= DATA_ZERO;
            tail_q    <= DATA_ZERO;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            occ_q     <= occ_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            valid_q   <= (occ_d != 2'd0);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign bus.o_rinc  = pop_s;
    assign bus.o_data  = head_q;
    assign bus.o_valid = valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_aborted   = aborted_q;
    assign o_count     = count_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;
    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_burst_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_len     (len),
        .i_abort   (abort),
        .bus       (bus),
        .o_busy    (busy),
        .o_done    (done),
        .o_aborted (aborted),
        .o_count   (count)
    );

    // FIFO model: 16-entry fall-through queue, popped on o_rinc.
    logic [DW-1:0] mem [0:15];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    logic          force_empty;

    assign bus.i_rempty = force_empty || (rd_ptr == wr_ptr);
    assign bus.i_rdata  = mem[rd_ptr[3:0]];

    always @(posedge clk) begin
        if (bus.o_rinc) rd_ptr <= rd_ptr + 1;
    end

    // Stream monitor: records delivered words, pulses, and protocol breaches.
    logic [DW-1:0] got_mem [0:63];
    int            got_n = 0;
    int            done_n = 0;
    int            abort_n = 0;
    int            viol_n = 0;
    int            stab_n = 0;
    int            occ_m = 0;
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic          prev_flush = 1'b1;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
            got_mem[got_n[5:0]] <= bus.o_data;
            got_n <= got_n + 1;
        end
        if (done === 1'b1) done_n <= done_n + 1;
        if (aborted === 1'b1) abort_n <= abort_n + 1;
        if (bus.o_rinc === 1'b1 && occ_m == 2) viol_n <= viol_n + 1;
        if (prev_valid && !prev_ready && !prev_flush &&
            (bus.o_valid !== 1'b1 || bus.o_data !== prev_data)) stab_n <= stab_n + 1;
        prev_valid <= (bus.o_valid === 1'b1);
        prev_ready <= (bus.i_ready === 1'b1);
        prev_data  <= bus.o_data;
        prev_flush <= (rst === 1'b1) || (abort === 1'b1 && busy === 1'b1);
        if (rst === 1'b1 || (abort === 1'b1 && busy === 1'b1)) occ_m <= 0;
        else occ_m <= occ_m + ((bus.o_rinc === 1'b1) ? 1 : 0)
                            - ((bus.o_valid === 1'b1 && bus.i_ready === 1'b1) ? 1 : 0);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] v);
        mem[wr_ptr[3:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic flush_fifo;
        wr_ptr = rd_ptr;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0;
        force_empty = 1'b0; bus.i_ready = 1'b0;
        tick; tick;
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.o_valid); end
        total++; if (bus.o_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.o_data); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin bad++;
            $display("FAIL reset_flags got busy=%0b done=%0b aborted=%0b exp=0", busy, done, aborted); end
        total++; if (count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (bus.o_rinc !== 1'b0) begin bad++; $display("FAIL reset_rinc got=%0b exp=0", bus.o_rinc); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_full_rate;
        int rd0;
        flush_fifo();
        for (int i = 0; i < 6; i++) load(8'h10 + 8'(i));
        bus.i_ready = 1'b1;
        rd0 = rd_ptr;
        start = 1'b1; len = 8'd5;
        tick;
        start = 1'b0;
        total++; if (bus.o_rinc !== 1'b1 || bus.o_valid !== 1'b0 || busy !== 1'b1) begin bad++;
            $display("FAIL fr_first got rinc=%0b valid=%0b busy=%0b exp 1/0/1", bus.o_rinc, bus.o_valid, busy); end
        for (int k = 0; k < 5; k++) begin
            tick;
            total++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h10 + 8'(k)) begin bad++;
                $display("FAIL fr_data%0d got valid=%0b data=%h exp 1/%h", k, bus.o_valid, bus.o_data, 8'h10 + 8'(k)); end
            total++; if (bus.o_rinc !== (k < 4)) begin bad++;
                $display("FAIL fr_rinc%0d got=%0b exp=%0b", k, bus.o_rinc, (k < 4)); end
        end
        tick;
        total++; if (done !== 1'b1 || busy !== 1'b0 || bus.o_valid !== 1'b0) begin bad++;
            $display("FAIL fr_done got done=%0b busy=%0b valid=%0b exp 1/0/0", done, busy, bus.o_valid); end
        total++; if (count !== 8'd5) begin bad++; $display("FAIL fr_count got=%0d exp=5", count); end
        tick;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL fr_done_pulse got=%0b exp=0", done); end
        total++; if (rd_ptr - rd0 != 5 || bus.i_rempty !== 1'b0 || bus.i_rdata !== 8'h15) begin bad++;
            $display("FAIL fr_sixth got pops=%0d head=%h exp 5/15", rd_ptr - rd0, bus.i_rdata); end
        flush_fifo();
    endtask

    task automatic test_zero_len;
        start = 1'b1; len = 8'd0;
        tick;
        start = 1'b0;
        total++; if (bus.o_rinc !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL zl_idle got rinc=%0b busy=%0b exp 0/0", bus.o_rinc, busy); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zl_done got=%0b exp=1", done); end
        total++; if (count !== 8'd0) begin bad++; $display("FAIL zl_count got=%0d exp=0", count); end
        tick;
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL zl_after got done=%0b busy=%0b exp 0/0", done, busy); end
    endtask

    task automatic test_backpressure;
        int g0, d0;
        logic seen;
        flush_fifo();
        for (int i = 0; i < 4; i++) load(8'hA0 + 8'(i));
        g0 = got_n; d0 = done_n; seen = 1'b0;
        bus.i_ready = 1'b0;
        start = 1'b1; len = 8'd4;
        tick;
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            bus.i_ready = ~bus.i_ready;
            tick;
            if (done === 1'b1) begin seen = 1'b1; break; end
        end
        bus.i_ready = 1'b1;
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL bp_timeout got done=0 exp=1"); end
        tick;
        total++; if (got_n - g0 != 4) begin bad++; $display("FAIL bp_words got=%0d exp=4", got_n - g0); end
        for (int j = 0; j < 4; j++) begin
            total++; if (got_mem[(g0 + j) % 64] !== 8'hA0 + 8'(j)) begin bad++;
                $display("FAIL bp_word%0d got=%h exp=%h", j, got_mem[(g0 + j) % 64], 8'hA0 + 8'(j)); end
        end
        total++; if (viol_n != 0) begin bad++; $display("FAIL bp_pop_full got=%0d exp=0", viol_n); end
        total++; if (stab_n != 0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stab_n); end
        total++; if (count !== 8'd4) begin bad++; $display("FAIL bp_count got=%0d exp=4", count); end
        total++; if (done_n - d0 != 1) begin bad++; $display("FAIL bp_done_pulses got=%0d exp=1", done_n - d0); end
    endtask

    task automatic test_empty_wait;
        int g0;
        logic seen;
        flush_fifo();
        force_empty = 1'b1;
        load(8'h01); load(8'h02); load(8'h03);
        bus.i_ready = 1'b1;
        g0 = got_n; seen = 1'b0;
        start = 1'b1; len = 8'd3;
        tick;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            total++; if (busy !== 1'b1 || bus.o_rinc !== 1'b0) begin bad++;
                $display("FAIL ew_hold%0d got busy=%0b rinc=%0b exp 1/0", i, busy, bus.o_rinc); end
            tick;
        end
        force_empty = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (done === 1'b1) begin seen = 1'b1; break; end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL ew_timeout got done=0 exp=1"); end
        tick;
        total++; if (got_n - g0 != 3) begin bad++; $display("FAIL ew_words got=%0d exp=3", got_n - g0); end
        for (int j = 0; j < 3; j++) begin
            total++; if (got_mem[(g0 + j) % 64] !== 8'h01 + 8'(j)) begin bad++;
                $display("FAIL ew_word%0d got=%h exp=%h", j, got_mem[(g0 + j) % 64], 8'h01 + 8'(j)); end
        end
        total++; if (count !== 8'd3) begin bad++; $display("FAIL ew_count got=%0d exp=3", count); end
    endtask

    task automatic test_abort;
        int rd0, a0, d0;
        flush_fifo();
        for (int i = 0; i < 8; i++) load(8'h30 + 8'(i));
        bus.i_ready = 1'b0;
        rd0 = rd_ptr; a0 = abort_n; d0 = done_n;
        start = 1'b1; len = 8'd8;
        tick;
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        total++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h30) begin bad++;
            $display("FAIL ab_held got valid=%0b data=%h exp 1/30", bus.o_valid, bus.o_data); end
        abort = 1'b1;
        #1;
        total++; if (bus.o_rinc !== 1'b0) begin bad++; $display("FAIL ab_no_pop got=%0b exp=0", bus.o_rinc); end
        tick;
        abort = 1'b0;
        total++; if (bus.o_valid !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL ab_flush got valid=%0b busy=%0b exp 0/0", bus.o_valid, busy); end
        total++; if (aborted !== 1'b1 || done !== 1'b0) begin bad++;
            $display("FAIL ab_pulse got aborted=%0b done=%0b exp 1/0", aborted, done); end
        total++; if (count !== 8'd0) begin bad++; $display("FAIL ab_count got=%0d exp=0", count); end
        total++; if (rd_ptr - rd0 != 2) begin bad++; $display("FAIL ab_pops got=%0d exp=2", rd_ptr - rd0); end
        tick;
        total++; if (aborted !== 1'b0) begin bad++; $display("FAIL ab_pulse_len got=%0b exp=0", aborted); end
        tick;
        total++; if (abort_n - a0 != 1 || done_n - d0 != 0) begin bad++;
            $display("FAIL ab_counts got aborts=%0d dones=%0d exp 1/0", abort_n - a0, done_n - d0); end
        flush_fifo();
    endtask

    task automatic test_start_ignored;
        int rd0, g0;
        logic seen;
        flush_fifo();
        for (int i = 0; i < 4; i++) load(8'h40 + 8'(i));
        bus.i_ready = 1'b1;
        rd0 = rd_ptr; g0 = got_n; seen = 1'b0;
        start = 1'b1; len = 8'd2;
        tick;
        len = 8'd4;
        tick;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin seen = 1'b1; break; end
            tick;
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL si_timeout got done=0 exp=1"); end
        tick;
        total++; if (rd_ptr - rd0 != 2 || count !== 8'd2) begin bad++;
            $display("FAIL si_len got pops=%0d count=%0d exp 2/2", rd_ptr - rd0, count); end
        total++; if (got_n - g0 != 2 || got_mem[g0 % 64] !== 8'h40 || got_mem[(g0 + 1) % 64] !== 8'h41) begin bad++;
            $display("FAIL si_words got n=%0d exp n=2 data 40,41", got_n - g0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL si_idle got busy=%0b exp=0", busy); end
        flush_fifo();
    endtask

    task automatic test_reset_mid;
        int rd0, g0;
        logic seen;
        flush_fifo();
        for (int i = 0; i < 5; i++) load(8'h50 + 8'(i));
        bus.i_ready = 1'b0;
        rd0 = rd_ptr;
        start = 1'b1; len = 8'd5;
        tick;
        start = 1'b0;
        tick; tick; tick;
        total++; if (bus.o_valid !== 1'b1 || bus.o_data !== 8'h50 || rd_ptr - rd0 != 2) begin bad++;
            $display("FAIL rm_pre got valid=%0b data=%h pops=%0d exp 1/50/2", bus.o_valid, bus.o_data, rd_ptr - rd0); end
        rst = 1'b1;
        #1;
        total++; if (bus.o_rinc !== 1'b0) begin bad++; $display("FAIL rm_rinc got=%0b exp=0", bus.o_rinc); end
        tick;
        rst = 1'b0;
        total++; if (bus.o_valid !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin bad++;
            $display("FAIL rm_after got valid=%0b busy=%0b count=%0d exp 0/0/0", bus.o_valid, busy, count); end
        total++; if (rd_ptr - rd0 != 2) begin bad++; $display("FAIL rm_pops got=%0d exp=2", rd_ptr - rd0); end
        flush_fifo();
        load(8'h55); load(8'h66);
        bus.i_ready = 1'b1;
        g0 = got_n; seen = 1'b0;
        start = 1'b1; len = 8'd2;
        tick;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (done === 1'b1) begin seen = 1'b1; break; end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rm_timeout got done=0 exp=1"); end
        tick;
        total++; if (got_n - g0 != 2 || got_mem[g0 % 64] !== 8'h55 || got_mem[(g0 + 1) % 64] !== 8'h66) begin bad++;
            $display("FAIL rm_words got n=%0d exp n=2 data 55,66", got_n - g0); end
        total++; if (count !== 8'd2) begin bad++; $display("FAIL rm_count got=%0d exp=2", count); end
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_zero_len();
        test_backpressure();
        test_empty_wait();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
